boot_image_loader: RTL and testbench
====================================

Name: boot_image_loader

Overview:
- Consumes the 16-bit word stream from the UFM reader (`data`/`adr`/`wr`/`done`) at power-up.
- Writes each word into the J1 program RAM write port and counts accepted words.
- Optionally validates an additive checksum.
- Holds the J1 CPU in reset until the image is complete and valid, then releases it.

Parameters:
- AW, 11, loader/RAM word-address width.
- DW, 16, data word width.
- EXP_WORDS, 2048, exact number of accepted writes required for a valid image.
- SETTLE_CYC, 16, cycles waited after `done` before check/release (range 1..255).

Ports:
- clk  in  1  system clock (50 MHz, same domain as the UFM reader).
- resetn  in  1  asynchronous active-low reset.
- ld_data  in  DW  word from UFM reader.
- ld_adr  in  AW  word address from UFM reader.
- ld_wr  in  1  write strobe from reader; combinational upstream, registered here.
- ld_done  in  1  reader-finished level; stays high once set.
- ram_we  out  1  program RAM write enable, single-cycle.
- ram_adr  out  AW  program RAM write address.
- ram_wdata  out  DW  program RAM write data.
- cpu_rstn  out  1  active-low reset to J1 core.
- boot_ok  out  1  image loaded and valid; CPU running.
- boot_err  out  1  image invalid; CPU held in reset.
- word_cnt  out  AW+1  accepted-write count, saturating.

Behaviour:
- Reset state:
  - All outputs 0; `cpu_rstn`=0.
  - FSM in LOAD; checksum accumulator 0; settle counter 0.
- Input stage:
  - `ld_wr`, `ld_adr`, `ld_data`, `ld_done` are registered once (r1) to remove upstream decode glitches.
  - `wr_pulse` = r1 `ld_wr` & ~r2 `ld_wr`, i.e. rising edge. One accept per strobe regardless of strobe length.
- Write path:
  - In LOAD, `wr_pulse` drives `ram_we`=1 for exactly one cycle.
  - `ram_adr`/`ram_wdata` carry the r1 address/data, so the write lands 2 cycles after the rising edge of `ld_wr`.
  - `ram_adr`/`ram_wdata` hold their last value when `ram_we`=0.
- `word_cnt`:
  - Increments on each accepted write.
  - Saturates at 2^AW; never wraps to 0.
- Ignored writes:
  - Any `wr_pulse` outside LOAD is ignored: no `ram_we`, no count.
- FSM states:
  - LOAD -> SETTLE on first cycle r1 `ld_done`=1.
    - A `wr_pulse` in that same cycle is still accepted; done and write are simultaneous.
  - SETTLE: counts SETTLE_CYC cycles, then -> CHECK.
  - CHECK: one cycle.
    - Goes to RUN if `word_cnt`==EXP_WORDS and the checksum passes (see Optional Feature).
    - Otherwise goes to FAIL.
  - RUN: `cpu_rstn`=1, `boot_ok`=1. Terminal until `resetn`.
  - FAIL: `cpu_rstn`=0, `boot_err`=1. Terminal until `resetn`.
- Output timing:
  - `cpu_rstn`, `boot_ok` and `boot_err` are registered.
  - They change the cycle after CHECK.
  - `boot_ok` and `boot_err` are never both 1.
- Reset mid-operation:
  - Asynchronous; immediately returns everything to reset state, including mid-SETTLE or in RUN.
  - `cpu_rstn` drops asynchronously with `resetn`.
- If `ld_done` never rises, the block stays in LOAD indefinitely with `cpu_rstn`=0. No timeout.
- Duplicate addresses are written and counted normally; the last write wins in RAM.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined:
  - A DW-bit modulo-2^DW accumulator adds `ram_wdata` on every accepted write.
  - CHECK requires accumulator == 0. The image carries a complement word so that the total sums to 0.
- Not defined:
  - No accumulator logic.
  - CHECK tests `word_cnt` only.

Test Plan:
- Happy path: 2048 writes at adr 0..2047, data=adr, `ld_done` after last. Expect:
  - 2048 `ram_we` pulses with matching adr/data.
  - `word_cnt`=2048.
  - `cpu_rstn`=1 and `boot_ok`=1 exactly 2+SETTLE_CYC+1 cycles after r1 `ld_done`.
- Short image: 2047 writes then `done` -> `boot_err`=1, `cpu_rstn` stays 0, `boot_ok`=0.
- Long strobe: `ld_wr` held high 4 cycles per word, plus a write after `done` -> exactly one `ram_we` per strobe; the post-done write is not written and not counted.
- Checksum (BOOT_CHECKSUM_EN defined):
  - 2047 words of 0x0001 plus final word 0xF801 -> `boot_ok`=1.
  - Final word changed to 0xF800 -> `boot_err`=1.
  - Same second image with the macro undefined -> `boot_ok`=1.
- Simultaneity: last `wr_pulse` in the same r1 cycle as `ld_done` -> write accepted, `word_cnt`=2048, `boot_ok`=1.
- Reset: assert `resetn`=0 mid-SETTLE and again while in RUN -> all outputs 0 immediately; a reload with a full image again reaches `boot_ok`=1.

Source files
------------

// File: rtl/boot_image_loader.sv
// Boot image loader: copies the UFM word stream into J1 program RAM and
// releases the CPU once the image is complete. Optional checksum: BOOT_CHECKSUM_EN.
module boot_image_loader #(
    parameter int AW         = 11,
    parameter int DW         = 16,
    parameter int EXP_WORDS  = 2048,
    parameter int SETTLE_CYC = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [DW-1:0] ld_data,
    input  logic [AW-1:0] ld_adr,
    input  logic          ld_wr,
    input  logic          ld_done,
    output logic          ram_we,
    output logic [AW-1:0] ram_adr,
    output logic [DW-1:0] ram_wdata,
    output logic          cpu_rstn,
    output logic          boot_ok,
    output logic          boot_err,
    output logic [AW:0]   word_cnt
);

    typedef enum logic [2:0] {
        LOAD,
        SETTLE,
        CHECK,
        RUN,
        FAIL
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [AW:0] EXP_CNT    = (AW + 1)'(EXP_WORDS);
    localparam logic [AW:0] CNT_MAX    = {1'b1, {AW{1'b0}}};

    state_t        state;
    state_t        state_n;
    logic          wr_r1;
    logic          wr_r2;
    logic          done_r1;
    logic [AW-1:0] adr_r1;
    logic [DW-1:0] data_r1;
    logic [7:0]    settle_cnt;
    logic          wr_pulse;
    logic          accept;
    logic          sum_ok;
    logic          image_ok;

    // Upstream decode can glitch, so every input is retimed before use.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_r1   <= 1'b0;
            wr_r2   <= 1'b0;
            done_r1 <= 1'b0;
            adr_r1  <= '0;
            data_r1 <= '0;
        end else begin
            wr_r1   <= ld_wr;
            wr_r2   <= wr_r1;
            done_r1 <= ld_done;
            adr_r1  <= ld_adr;
            data_r1 <= ld_data;
        end
    end

    assign wr_pulse = wr_r1 & ~wr_r2;
    assign accept   = wr_pulse && (state == LOAD);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ram_we    <= 1'b0;
            ram_adr   <= '0;
            ram_wdata <= '0;
            word_cnt  <= '0;
        end else begin
            ram_we <= accept;
            if (accept) begin
                ram_adr   <= adr_r1;
                ram_wdata <= data_r1;
                if (word_cnt != CNT_MAX) begin
                    word_cnt <= word_cnt + (AW + 1)'(1);
                end
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    logic [DW-1:0] csum;

    // The image ends with a complement word, so a good image sums to zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum + data_r1;
        end
    end

    assign sum_ok = (csum == '0);
`else
    assign sum_ok = 1'b1;
`endif

    assign image_ok = (word_cnt == EXP_CNT) && sum_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            settle_cnt <= '0;
        end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt + 8'd1;
        end else begin
            settle_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= LOAD;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            LOAD: begin
                if (done_r1) begin
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_n = CHECK;
                end
            end
            CHECK: begin
                state_n = image_ok ? RUN : FAIL;
            end
            RUN:     state_n = RUN;
            FAIL:    state_n = FAIL;
            default: state_n = LOAD;
        endcase
    end

    // Terminal states drive the CPU-facing flags one cycle later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cpu_rstn <= 1'b0;
            boot_ok  <= 1'b0;
            boot_err <= 1'b0;
        end else begin
            cpu_rstn <= (state == RUN);
            boot_ok  <= (state == RUN);
            boot_err <= (state == FAIL);
        end
    end

endmodule

// File: tb/tb_boot_image_loader.sv
// Directed bench for boot_image_loader: table of image loads plus
// hand-written reset and no-done sequences.
module tb_boot_image_loader;

    localparam int AW = 11;
    localparam int DW = 16;
    localparam int S  = 16;

    typedef struct {
        int          n;
        int          mode;
        logic [15:0] last;
        int          len;
        bit          simul;
        bit          post;
        bit          ok;
        int          cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic [AW-1:0] ld_adr = '0;
    logic          ld_wr = 1'b0;
    logic          ld_done = 1'b0;
    logic          ram_we;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_wdata;
    logic          cpu_rstn;
    logic          boot_ok;
    logic          boot_err;
    logic [AW:0]   word_cnt;

    boot_image_loader #(
        .AW(AW),
        .DW(DW),
        .EXP_WORDS(2048),
        .SETTLE_CYC(S)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .ld_data(ld_data),
        .ld_adr(ld_adr),
        .ld_wr(ld_wr),
        .ld_done(ld_done),
        .ram_we(ram_we),
        .ram_adr(ram_adr),
        .ram_wdata(ram_wdata),
        .cpu_rstn(cpu_rstn),
        .boot_ok(boot_ok),
        .boot_err(boot_err),
        .word_cnt(word_cnt)
    );

    always #10 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_edge = 0;
    int          we_cnt = 0;
    int          bad = 0;
    int          both_cnt = 0;
    int          m_cnt = 0;
    logic [15:0] m_sum = '0;
    logic [26:0] exp_q[$];
    vec_t        vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [26:0] e;
        if (boot_ok && boot_err) both_cnt++;
        if (resetn && ram_we) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                bad++;
            end else begin
                e = exp_q.pop_front();
                if ({ram_adr, ram_wdata} !== e) bad++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({ram_we, cpu_rstn, boot_ok, boot_err,
                    word_cnt, ram_adr, ram_wdata});
    endfunction

    task automatic do_reset(input string tag);
        resetn  = 1'b0;
        ld_wr   = 1'b0;
        ld_done = 1'b0;
        ld_adr  = '0;
        ld_data = '0;
        #1;
        check(tag, all_outs(), 64'd0);
        exp_q.delete();
        we_cnt = 0;
        bad    = 0;
        m_cnt  = 0;
        m_sum  = '0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic strobe(input logic [10:0] a, input logic [15:0] d,
                          input int len, input bit with_done);
        ld_adr  = a;
        ld_data = d;
        ld_wr   = 1'b1;
        if (with_done) begin
            done_edge = cyc + 1;
            ld_done   = 1'b1;
        end
        repeat (len) @(negedge clk);
        ld_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive_image(input vec_t v);
        logic [10:0] a;
        logic [15:0] d;
        bit          lst;
        for (int i = 0; i < v.n; i++) begin
            lst = (i == v.n - 1);
            a   = i[10:0];
            if (v.mode == 0) d = i[15:0];
            else             d = lst ? v.last : 16'h0001;
            exp_q.push_back({a, d});
            if (m_cnt < 2048) m_cnt++;
            m_sum = m_sum + d;
            strobe(a, d, v.len, lst && v.simul);
        end
        if (!v.simul) begin
            done_edge = cyc + 1;
            ld_done   = 1'b1;
            @(negedge clk);
        end
        if (v.post) begin
            @(negedge clk);
            strobe(11'd5, 16'hBEEF, 2, 1'b0);
        end
    endtask

    task automatic poll_boot();
        int t;
        t = 0;
        while (!(boot_ok || boot_err) && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    initial begin
        bit ok;
        vecs[0] = '{2048, 0, 16'h0000, 1, 1'b0, 1'b0, 1'b1, 2048};
        vecs[1] = '{2047, 0, 16'h0000, 1, 1'b0, 1'b0, 1'b0, 2047};
        vecs[2] = '{2048, 0, 16'h0000, 4, 1'b0, 1'b1, 1'b1, 2048};
        vecs[3] = '{2048, 1, 16'hF801, 1, 1'b0, 1'b0, 1'b1, 2048};
        vecs[4] = '{2048, 1, 16'hF800, 1, 1'b0, 1'b0, 1'b1, 2048};
        vecs[5] = '{2048, 0, 16'h0000, 1, 1'b1, 1'b0, 1'b1, 2048};
        vecs[6] = '{2049, 0, 16'h0000, 1, 1'b0, 1'b0, 1'b1, 2048};

        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            do_reset($sformatf("v%0d_reset", k));
            drive_image(vecs[k]);
            poll_boot();
            ok = vecs[k].ok;
`ifdef BOOT_CHECKSUM_EN
            ok = ok && (m_sum == 16'h0000);
`endif
            check($sformatf("v%0d_latency", k), 64'(cyc - done_edge),
                  64'(S + 3));
            check($sformatf("v%0d_word_cnt", k), 64'(word_cnt),
                  64'(vecs[k].cnt));
            check($sformatf("v%0d_we_pulses", k), 64'(we_cnt),
                  64'(vecs[k].n));
            check($sformatf("v%0d_wr_adr_data", k), 64'(bad), 64'd0);
            check($sformatf("v%0d_wr_pending", k), 64'(exp_q.size()),
                  64'd0);
            check($sformatf("v%0d_status", k),
                  64'({cpu_rstn, boot_ok, boot_err}),
                  ok ? 64'b110 : 64'b001);
        end

        do_reset("nodone_reset");
        for (int i = 0; i < 10; i++) begin
            strobe(i[10:0], i[15:0], 1, 1'b0);
        end
        repeat (60) @(negedge clk);
        check("nodone_hold", 64'({cpu_rstn, boot_ok, boot_err}), 64'd0);
        check("nodone_cnt", 64'(word_cnt), 64'd10);

        do_reset("settle_pre_reset");
        drive_image(vecs[3]);
        repeat (6) @(negedge clk);
        check("settle_loaded", 64'(word_cnt), 64'd2048);
        check("settle_hold", 64'({cpu_rstn, boot_ok, boot_err}), 64'd0);
        #3;
        do_reset("settle_async_reset");
        drive_image(vecs[3]);
        poll_boot();
        check("reload1_status", 64'({cpu_rstn, boot_ok, boot_err}),
              64'b110);
        #3;
        do_reset("run_async_reset");
        drive_image(vecs[3]);
        poll_boot();
        check("reload2_status", 64'({cpu_rstn, boot_ok, boot_err}),
              64'b110);
        check("reload2_cnt", 64'(word_cnt), 64'd2048);
        check("never_both", 64'(both_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
